// File: rtl/fp_mul_const_top.sv
// rtl/fp_mul_const_top.sv - two-stage binary32 multiplier of two constant operands
// Stage 1 classifies and multiplies the significands; stage 2 normalises, rounds and packs.
module fp_mul_const_top #(
    parameter logic [31:0] OP_A = 32'h3F8F8034,
    parameter logic [31:0] OP_B = 32'h3F800000
) (
    input  logic        clk,
    input  logic        rstn,
    output logic [31:0] result
);

    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_SUB,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fp_class_e;

    function automatic fp_class_e classify(input logic [7:0] e, input logic [22:0] m);
        fp_class_e c;
        if (e == 8'd0) begin
            c = (m == 23'd0) ? CLS_ZERO : CLS_SUB;
        end else if (e == 8'hFF) begin
            c = (m == 23'd0) ? CLS_INF : CLS_NAN;
        end else begin
            c = CLS_NORM;
        end
        return c;
    endfunction

    // ---------------- stage 1 ----------------
    logic        s_a, s_b;
    logic [7:0]  e_a, e_b;
    logic [22:0] m_a, m_b;
    fp_class_e   cls_a, cls_b;
    logic        zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;

    assign s_a = OP_A[31];
    assign e_a = OP_A[30:23];
    assign m_a = OP_A[22:0];
    assign s_b = OP_B[31];
    assign e_b = OP_B[30:23];
    assign m_b = OP_B[22:0];

    assign cls_a = classify(e_a, m_a);
    assign cls_b = classify(e_b, m_b);

    // Subnormals are flushed, so they count as zero everywhere below.
    assign zero_a = (cls_a == CLS_ZERO) || (cls_a == CLS_SUB);
    assign zero_b = (cls_b == CLS_ZERO) || (cls_b == CLS_SUB);
    assign inf_a  = (cls_a == CLS_INF);
    assign inf_b  = (cls_b == CLS_INF);
    assign nan_a  = (cls_a == CLS_NAN);
    assign nan_b  = (cls_b == CLS_NAN);

    logic               sign_d, sign_q;
    logic signed [9:0]  exp_d, exp_q;
    logic [47:0]        mant_d, mant_q;
    logic               nan_d, nan_q;
    logic               inf_d, inf_q;
    logic               zero_d, zero_q;
    logic               vld_q;

    always_comb begin
        sign_d = s_a ^ s_b;
        exp_d  = $signed({2'b00, e_a}) + $signed({2'b00, e_b}) - 10'sd127;
        mant_d = {1'b1, m_a} * {1'b1, m_b};
        nan_d  = nan_a | nan_b | (inf_a & zero_b) | (inf_b & zero_a);
        inf_d  = inf_a | inf_b;
        zero_d = zero_a | zero_b;
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            sign_q <= 1'b0;
            exp_q  <= '0;
            mant_q <= '0;
            nan_q  <= 1'b0;
            inf_q  <= 1'b0;
            zero_q <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            sign_q <= sign_d;
            exp_q  <= exp_d;
            mant_q <= mant_d;
            nan_q  <= nan_d;
            inf_q  <= inf_d;
            zero_q <= zero_d;
            vld_q  <= 1'b1;
        end
    end

    // ---------------- stage 2 ----------------
    logic [23:0]       sig_n;
    logic              guard, rnd, sticky, round_up;
    logic [24:0]       sig_r;
    logic signed [9:0] exp_n, exp_f;
    logic [22:0]       frac_f;
    logic [31:0]       result_d, result_q;

    always_comb begin
        if (mant_q[47]) begin
            sig_n  = mant_q[47:24];
            guard  = mant_q[23];
            rnd    = mant_q[22];
            sticky = |mant_q[21:0];
            exp_n  = exp_q + 10'sd1;
        end else begin
            sig_n  = mant_q[46:23];
            guard  = mant_q[22];
            rnd    = mant_q[21];
            sticky = |mant_q[20:0];
            exp_n  = exp_q;
        end

        // Ties go to the even significand.
        round_up = guard & (rnd | sticky | sig_n[0]);
        sig_r    = {1'b0, sig_n} + {24'd0, round_up};

        if (sig_r[24]) begin
            exp_f  = exp_n + 10'sd1;
            frac_f = sig_r[23:1];
        end else begin
            exp_f  = exp_n;
            frac_f = sig_r[22:0];
        end

        result_d = 32'h0000_0000;
        if (!vld_q) begin
            result_d = 32'h0000_0000;
        end else if (nan_q) begin
            result_d = QNAN;
        end else if (inf_q) begin
            result_d = {sign_q, 8'hFF, 23'd0};
        end else if (zero_q) begin
            result_d = {sign_q, 31'd0};
        end else if (exp_f >= 10'sd255) begin
            result_d = {sign_q, 8'hFF, 23'd0};
        end else if (exp_f <= 10'sd0) begin
            result_d = {sign_q, 31'd0};
        end else begin
            result_d = {sign_q, exp_f[7:0], frac_f};
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            result_q <= 32'h0000_0000;
        end else begin
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_fp_mul_const_top.sv
// tb/tb_fp_mul_const_top.sv - bench for fp_mul_const_top over a table of operand pairs
module tb_fp_mul_const_top;

    localparam int N = 20;

    logic clk = 1'b0;
    logic rstn;
    logic [N-1:0][31:0] res;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] op_a(input int i);
        case (i)
            0:  return 32'h3F8F8034;
            1:  return 32'h40000000;
            2:  return 32'h3FC00000;
            3:  return 32'hC0000000;
            4:  return 32'h7F800000;
            5:  return 32'h7F7FFFFF;
            6:  return 32'h3F800001;
            7:  return 32'h00800000;
            8:  return 32'h7FC12345;
            9:  return 32'hFF800000;
            10: return 32'h80000000;
            11: return 32'h00400000;
            12: return 32'h3F800800;
            13: return 32'h3FC00001;
            14: return 32'h3FAAAAAB;
            15: return 32'h0DA24260;
            16: return 32'h7F000000;
            17: return 32'h3FFFFFFF;
            18: return 32'h3FB71B00;
            default: return 32'hFF812345;
        endcase
    endfunction

    function automatic logic [31:0] op_b(input int i);
        case (i)
            0:  return 32'h3F800000;
            1:  return 32'h40400000;
            2:  return 32'h3FC00000;
            3:  return 32'h3F000000;
            4:  return 32'h00000000;
            5:  return 32'h40000000;
            6:  return 32'h3F800001;
            7:  return 32'h3F000000;
            8:  return 32'hBF800000;
            9:  return 32'h40400000;
            10: return 32'h42F60000;
            11: return 32'h7F000000;
            12: return 32'h3F800800;
            13: return 32'h3FC00000;
            14: return 32'hC0400000;
            15: return 32'h12345678;
            16: return 32'h3FFFFFFF;
            17: return 32'h3FFFFFFF;
            18: return 32'h3FB2F4FC;
            default: return 32'h00000000;
        endcase
    endfunction

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_dut
            fp_mul_const_top #(
                .OP_A(op_a(g)),
                .OP_B(op_b(g))
            ) u_dut (
                .clk   (clk),
                .rstn  (rstn),
                .result(res[g])
            );
        end
    endgenerate

    // Reference: exact significand product in real arithmetic, scaled to [2^23, 2^24) and rounded.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic s;
        int   ea, eb, sa, sb, k, m, biased;
        logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        real  q, frac;
        s      = a[31] ^ b[31];
        ea     = int'(a[30:23]);
        eb     = int'(b[30:23]);
        a_nan  = (ea == 255) && (a[22:0] != 23'd0);
        b_nan  = (eb == 255) && (b[22:0] != 23'd0);
        a_inf  = (ea == 255) && (a[22:0] == 23'd0);
        b_inf  = (eb == 255) && (b[22:0] == 23'd0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        if (a_nan || b_nan) return 32'h7FC00000;
        if ((a_inf && b_zero) || (b_inf && a_zero)) return 32'h7FC00000;
        if (a_inf || b_inf) return {s, 8'hFF, 23'd0};
        if (a_zero || b_zero) return {s, 31'd0};
        sa = 8388608 + int'(a[22:0]);
        sb = 8388608 + int'(b[22:0]);
        q  = real'(sa) * real'(sb);
        k  = 0;
        while (q >= 16777216.0) begin
            q = q / 2.0;
            k++;
        end
        m    = $rtoi(q);
        frac = q - real'(m);
        if (frac > 0.5 || (frac == 0.5 && m[0])) m++;
        if (m == 16777216) begin
            m = 8388608;
            k++;
        end
        biased = k + ea + eb - 150;
        if (biased >= 255) return {s, 8'hFF, 23'd0};
        if (biased <= 0) return {s, 31'd0};
        return {s, biased[7:0], m[22:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input bit expect_zero);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s[%0d]", tag, i), res[i],
                  expect_zero ? 32'h0 : ref_mul(op_a(i), op_b(i)));
        end
    endtask

    initial begin
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("reset", 1'b1);

        rstn = 1'b0;
        @(posedge clk); #1;
        check_all("edge1", 1'b1);
        @(posedge clk); #1;
        check_all("edge2", 1'b0);

        check("plan_default", res[0],  32'h3F8F8034);
        check("plan_2x3",     res[1],  32'h40C00000);
        check("plan_1p5sq",   res[2],  32'h40100000);
        check("plan_sign",    res[3],  32'hBF800000);
        check("plan_infx0",   res[4],  32'h7FC00000);
        check("plan_ovf",     res[5],  32'h7F800000);
        check("plan_rne",     res[6],  32'h3F800002);
        check("plan_uflow",   res[7],  32'h00000000);
        check("nan_in",       res[8],  32'h7FC00000);
        check("ninf_x3",      res[9],  32'hFF800000);
        check("nzero",        res[10], 32'h80000000);
        check("tie_even",     res[12], 32'h3F801000);
        check("rnd_carry",    res[18], 32'h40000000);

        for (int it = 0; it < 12; it++) begin
            int hold;
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
            check_all("steady", 1'b0);

            @(posedge clk);
            #($urandom_range(1, 8));
            rstn = 1'b1;
            #1;
            check_all("async_rst", 1'b1);
            hold = $urandom_range(0, 2);
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                check_all("held_rst", 1'b1);
            end

            @(negedge clk);
            rstn = 1'b0;
            @(posedge clk); #1;
            check_all("rel_edge1", 1'b1);
            if ($urandom_range(0, 1) == 1) begin
                #2;
                rstn = 1'b1;
                #1;
                check_all("mid_rst", 1'b1);
                @(negedge clk);
                rstn = 1'b0;
                @(posedge clk); #1;
                check_all("mid_edge1", 1'b1);
            end
            @(posedge clk); #1;
            check_all("rel_edge2", 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
